// File: rtl/dot_pair_sequencer.sv
// dot_pair_sequencer: drives a two-lane multiply-add pipeline over a vector
// of operand beats and accumulates the per-beat sums into a 32-bit result.
// Pipeline: stage 1 holds both lane products, stage 2 holds their sum, and
// the accumulator adds stage 2 whenever it carries a valid beat.
module dot_pair_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [LEN_W-1:0] Len,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [31:0]      A1,
    input  logic [31:0]      A2,
    input  logic [31:0]      B1,
    input  logic [31:0]      B2,
    output logic             Res_Valid,
    input  logic             Res_Ready,
    output logic [31:0]      Res,
    output logic             Busy,
    output logic [LEN_W-1:0] Beat_Count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_count_q, beat_count_d;
    logic [LEN_W-1:0]  beat_inc;
    logic [31:0]       p1_q, p1_d, p2_q, p2_d;
    logic [31:0]       s_q, s_d;
    logic [31:0]       acc_q, acc_d;
    logic              v1_q, v1_d, v2_q, v2_d;
    logic              clear;
    logic              fire;

    assign beat_inc = beat_count_q + LEN_W'(1);
    assign fire     = In_Ready & In_Valid;

    // Command FSM: next state and handshake/status outputs.
    always_comb begin
        state_d   = state_q;
        In_Ready  = 1'b0;
        Res_Valid = 1'b0;
        Busy      = 1'b1;
        clear     = 1'b0;
        case (state_q)
            IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    clear   = 1'b1;
                    state_d = (Len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                In_Ready = 1'b1;
                // The beat that completes the vector closes the input side.
                if (In_Valid && (beat_inc == len_q)) state_d = DRAIN;
            end
            DRAIN: begin
                // No new beats arrive here, so stage 2 valid with stage 1
                // empty means the final sum is landing in the accumulator.
                if (v2_q && !v1_q) state_d = DONE;
            end
            DONE: begin
                Res_Valid = 1'b1;
                if (Res_Ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: beat counting, product/sum stages and accumulation.
    always_comb begin
        len_d        = clear ? Len : len_q;
        beat_count_d = clear ? '0 : (fire ? beat_inc : beat_count_q);
        p1_d         = fire ? A1 * B1 : p1_q;
        p2_d         = fire ? A2 * B2 : p2_q;
        v1_d         = clear ? 1'b0 : fire;
        s_d          = p1_q + p2_q;
        v2_d         = clear ? 1'b0 : v1_q;
        acc_d        = clear ? '0 : (v2_q ? acc_q + s_q : acc_q);
    end

    // State and pipeline registers; reset discards any in-flight beats.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            beat_count_q <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            s_q          <= '0;
            acc_q        <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            beat_count_q <= beat_count_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            s_q          <= s_d;
            acc_q        <= acc_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
        end
    end

    assign Res        = acc_q;
    assign Beat_Count = beat_count_q;

endmodule

// File: tb/tb_dot_pair_sequencer.sv
// Self-checking bench for dot_pair_sequencer: a reference model builds each
// expected dot product into a scoreboard queue as beats are driven, and the
// entry is popped and compared when the result is offered.
module tb_dot_pair_sequencer;

    localparam int LEN_W = 8;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Start;
    logic [LEN_W-1:0] Len;
    logic             In_Valid;
    logic             In_Ready;
    logic [31:0]      A1, A2, B1, B2;
    logic             Res_Valid;
    logic             Res_Ready;
    logic [31:0]      Res;
    logic             Busy;
    logic [LEN_W-1:0] Beat_Count;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_acc;
    logic [31:0] sb_q[$];
    logic [31:0] exp_res;
    int          lat;

    dot_pair_sequencer #(.LEN_W(LEN_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Len(Len),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .A1(A1), .A2(A2), .B1(B1), .B2(B2),
        .Res_Valid(Res_Valid), .Res_Ready(Res_Ready), .Res(Res),
        .Busy(Busy), .Beat_Count(Beat_Count)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_cmd(input logic [LEN_W-1:0] n);
        Start   = 1'b1;
        Len     = n;
        exp_acc = '0;
        tick();
        Start   = 1'b0;
    endtask

    // One beat presented for exactly one edge; the model folds it in.
    task automatic send_beat(input logic [31:0] a1, input logic [31:0] b1,
                             input logic [31:0] a2, input logic [31:0] b2);
        logic [63:0] m1, m2;
        A1 = a1; B1 = b1; A2 = a2; B2 = b2;
        In_Valid = 1'b1;
        m1 = 64'(a1) * 64'(b1);
        m2 = 64'(a2) * 64'(b2);
        exp_acc = exp_acc + m1[31:0] + m2[31:0];
        tick();
        In_Valid = 1'b0;
    endtask

    // Bounded wait for Res_Valid; returns cycles waited (-1 on timeout).
    task automatic wait_res(output int cyc);
        cyc = 0;
        while (!Res_Valid && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!Res_Valid) cyc = -1;
    endtask

    task automatic release_result();
        Res_Ready = 1'b1;
        tick();
        Res_Ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; Len = '0; In_Valid = 1'b0; Res_Ready = 1'b0;
        A1 = '0; A2 = '0; B1 = '0; B2 = '0;
        tick(); tick();
        tests++;
        if ({In_Ready, Res_Valid, Busy, Beat_Count, Res} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b cnt=%0d res=%h, want all 0",
                     In_Ready, Res_Valid, Busy, Beat_Count, Res);
        end
        Reset = 1'b0;
        Res_Ready = 1'b1;
        tick();
        Res_Ready = 1'b0;
        tests++;
        if (Busy !== 1'b0 || Res_Valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_res_ready: busy=%b vld=%b, want 0 0", Busy, Res_Valid);
        end
    endtask

    task automatic test_single();
        start_cmd(8'd1);
        tests++;
        if (Busy !== 1'b1 || In_Ready !== 1'b1) begin
            fails++;
            $display("FAIL single_run: busy=%b rdy=%b, want 1 1", Busy, In_Ready);
        end
        send_beat(32'd2, 32'd3, 32'd4, 32'd5);
        sb_q.push_back(exp_acc);
        tests++;
        if (In_Ready !== 1'b0 || Beat_Count !== 8'd1 || Res_Valid !== 1'b0) begin
            fails++;
            $display("FAIL single_drain: rdy=%b cnt=%0d vld=%b, want 0 1 0",
                     In_Ready, Beat_Count, Res_Valid);
        end
        wait_res(lat);
        tests++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL single_latency: got %0d cycles, want 2", lat);
        end
        exp_res = sb_q.pop_front();
        tests++;
        if (Res !== exp_res || Res !== 32'd26) begin
            fails++;
            $display("FAIL single_res: got %0d, want %0d", Res, exp_res);
        end
        release_result();
        tests++;
        if (Busy !== 1'b0 || Res_Valid !== 1'b0) begin
            fails++;
            $display("FAIL single_release: busy=%b vld=%b, want 0 0", Busy, Res_Valid);
        end
    endtask

    task automatic test_back_to_back();
        start_cmd(8'd3);
        send_beat(32'd1, 32'd1, 32'd1, 32'd1);
        send_beat(32'd2, 32'd2, 32'd2, 32'd2);
        send_beat(32'd3, 32'd3, 32'd3, 32'd3);
        sb_q.push_back(exp_acc);
        tests++;
        if (In_Ready !== 1'b0 || Beat_Count !== 8'd3) begin
            fails++;
            $display("FAIL b2b_in_ready_drop: rdy=%b cnt=%0d, want 0 3", In_Ready, Beat_Count);
        end
        // Start pulsed while draining must not restart the command.
        Start = 1'b1; Len = 8'd5;
        tick();
        Start = 1'b0;
        tests++;
        if (Res_Valid !== 1'b0 || Busy !== 1'b1 || Beat_Count !== 8'd3) begin
            fails++;
            $display("FAIL b2b_drain_start: vld=%b busy=%b cnt=%0d, want 0 1 3",
                     Res_Valid, Busy, Beat_Count);
        end
        tick();
        exp_res = sb_q.pop_front();
        tests++;
        if (Res_Valid !== 1'b1 || Res !== exp_res || Res !== 32'd28) begin
            fails++;
            $display("FAIL b2b_res: vld=%b res=%0d, want 1 %0d", Res_Valid, Res, exp_res);
        end
        // Start coincident with the result handshake is ignored.
        Start = 1'b1; Len = 8'd2; Res_Ready = 1'b1;
        tick();
        Start = 1'b0; Res_Ready = 1'b0;
        tick();
        tests++;
        if (Busy !== 1'b0 || In_Ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_start_on_handshake: busy=%b rdy=%b, want 0 0", Busy, In_Ready);
        end
    endtask

    task automatic test_bubbles();
        start_cmd(8'd2);
        send_beat(32'd10, 32'd10, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        tests++;
        if (Beat_Count !== 8'd1 || In_Ready !== 1'b1) begin
            fails++;
            $display("FAIL bubble_gap: cnt=%0d rdy=%b, want 1 1", Beat_Count, In_Ready);
        end
        tests++;
        if (Res !== 32'd100) begin
            fails++;
            $display("FAIL bubble_acc_hold: got %0d, want 100", Res);
        end
        send_beat(32'd0, 32'd0, 32'd7, 32'd7);
        sb_q.push_back(exp_acc);
        wait_res(lat);
        tests++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL bubble_latency: got %0d cycles, want 2", lat);
        end
        exp_res = sb_q.pop_front();
        tests++;
        if (Res !== exp_res || Res !== 32'd149) begin
            fails++;
            $display("FAIL bubble_res: got %0d, want %0d", Res, exp_res);
        end
        release_result();
    endtask

    task automatic test_len0();
        start_cmd(8'd0);
        sb_q.push_back(exp_acc);
        exp_res = sb_q.pop_front();
        tests++;
        if (Res_Valid !== 1'b1 || Res !== exp_res) begin
            fails++;
            $display("FAIL len0_result: vld=%b res=%h, want 1 %h", Res_Valid, Res, exp_res);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (Res_Valid !== 1'b1 || Res !== exp_res || Busy !== 1'b1) begin
                fails++;
                $display("FAIL len0_hold%0d: vld=%b res=%h busy=%b, want 1 %h 1",
                         i, Res_Valid, Res, Busy, exp_res);
            end
        end
        release_result();
        tests++;
        if (Busy !== 1'b0 || Res_Valid !== 1'b0) begin
            fails++;
            $display("FAIL len0_release: busy=%b vld=%b, want 0 0", Busy, Res_Valid);
        end
    endtask

    task automatic test_wrap();
        start_cmd(8'd1);
        send_beat(32'hFFFF_FFFF, 32'd2, 32'd1, 32'd3);
        sb_q.push_back(exp_acc);
        wait_res(lat);
        exp_res = sb_q.pop_front();
        tests++;
        if (lat !== 2 || Res !== exp_res || Res !== 32'h0000_0001) begin
            fails++;
            $display("FAIL wrap_res: lat=%0d res=%h, want 2 %h", lat, Res, exp_res);
        end
        release_result();
    endtask

    task automatic test_reset_mid();
        start_cmd(8'd4);
        send_beat(32'd5, 32'd5, 32'd5, 32'd5);
        send_beat(32'd6, 32'd6, 32'd6, 32'd6);
        #2 Reset = 1'b1;
        #1;
        tests++;
        if ({In_Ready, Res_Valid, Busy, Beat_Count, Res} !== '0) begin
            fails++;
            $display("FAIL reset_async: rdy=%b vld=%b busy=%b cnt=%0d res=%h, want all 0",
                     In_Ready, Res_Valid, Busy, Beat_Count, Res);
        end
        tick();
        Reset = 1'b0;
        tick();
        start_cmd(8'd1);
        send_beat(32'd1, 32'd1, 32'd1, 32'd1);
        sb_q.push_back(exp_acc);
        wait_res(lat);
        exp_res = sb_q.pop_front();
        tests++;
        if (lat !== 2 || Res !== exp_res || Res !== 32'd2 || Beat_Count !== 8'd1) begin
            fails++;
            $display("FAIL reset_recover: lat=%0d res=%0d cnt=%0d, want 2 %0d 1",
                     lat, Res, Beat_Count, exp_res);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bubbles();
        test_len0();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
